// File: rtl/tsr_host_driver_if.sv
// Host-side bus bundle for tsr_host_driver.
//   Source stream : src_data/src_valid in, src_ready out (word accepted when both high)
//   Write bus     : axi_wr_data/addr/en/strobe out, wr_ready in (slave can take a write)
//   Read bus      : axi_rd_addr/en out, axi_rd_data in (combinational, same cycle as en)
// Modport master is the driver; modport slave is the environment (source + TSR slave).
interface tsr_host_driver_if #(
    parameter int AXI_ADDR_WIDTH = 20
);
    logic [63:0]               src_data;
    logic                      src_valid;
    logic                      src_ready;
    logic [63:0]               axi_wr_data;
    logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr;
    logic                      axi_wr_en;
    logic [7:0]                axi_wr_strobe;
    logic                      wr_ready;
    logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr;
    logic                      axi_rd_en;
    logic [63:0]               axi_rd_data;

    modport master (
        input  src_data, src_valid, wr_ready, axi_rd_data,
        output src_ready, axi_wr_data, axi_wr_addr, axi_wr_en, axi_wr_strobe,
               axi_rd_addr, axi_rd_en
    );

    modport slave (
        output src_data, src_valid, wr_ready, axi_rd_data,
        input  src_ready, axi_wr_data, axi_wr_addr, axi_wr_en, axi_wr_strobe,
               axi_rd_addr, axi_rd_en
    );
endinterface

// File: rtl/tsr_host_driver.sv
// Host driver for the TSR classifier: streams optional weight words and one
// image frame from a source stream onto the register write bus, polls the
// status register until the result is ready, then reads the class.
// Ports:
//   clk, rst_n         single clock, asynchronous active-low reset
//   start, load_weights start pulse (IDLE only); load_weights sampled at start
//   bus (master)       source stream, write bus and read bus
//   result_class       last classified sign (unchanged on timeout)
//   done               one-cycle completion pulse
//   timeout_err        sticky until the next start; set when polling exceeds budget
//   busy               high whenever not IDLE
module tsr_host_driver #(
    parameter int AXI_ADDR_WIDTH   = 20,
    parameter int NUM_WEIGHT_WORDS = 14173,
    parameter int NUM_INPUT_WORDS  = 384,
    parameter int TIMEOUT_CYCLES   = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_weights,
    tsr_host_driver_if.master bus,
    output logic [5:0]        result_class,
    output logic              done,
    output logic              timeout_err,
    output logic              busy
);
    localparam int AW   = AXI_ADDR_WIDTH;
    localparam int MAXW = (NUM_WEIGHT_WORDS > NUM_INPUT_WORDS) ? NUM_WEIGHT_WORDS : NUM_INPUT_WORDS;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_W      = CW'(NUM_WEIGHT_WORDS - 1);
    localparam logic [CW-1:0] LAST_P      = CW'(NUM_INPUT_WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] WEIGHT_BASE = AW'(32'hC19);
    localparam logic [AW-1:0] STATUS_ADDR = AW'(32'hC01);
    localparam logic [AW-1:0] RESULT_ADDR = AW'(32'hC00);

    typedef enum logic [2:0] {
        IDLE, WEIGHTS, PIXELS, POLL_WAIT, POLL_RD, RESULT_RD, DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      wait_q, wait_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            timeout_q, timeout_d;
    logic [5:0]      result_q, result_d;
    logic            wr_en_q;
    logic [63:0]     wr_data_q;
    logic [AW-1:0]   wr_addr_q;

    logic            src_ready;
    logic            accept;
    logic [AW-1:0]   wr_addr_nxt;
    logic            unused_rd_bits;

    assign src_ready   = ((state_q == WEIGHTS) || (state_q == PIXELS)) && bus.wr_ready;
    assign accept      = src_ready && bus.src_valid;
    assign wr_addr_nxt = (state_q == WEIGHTS) ? (WEIGHT_BASE + (AW'(cnt_q) << 3))
                                              : (AW'(cnt_q) << 3);
    assign unused_rd_bits = ^bus.axi_rd_data[63:6];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = load_weights ? WEIGHTS : PIXELS;
                    cnt_d     = '0;
                    tmo_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            WEIGHTS: begin
                if (accept) begin
                    if (cnt_q == LAST_W) begin
                        state_d = PIXELS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PIXELS: begin
                if (accept) begin
                    if (cnt_q == LAST_P) begin
                        state_d = POLL_WAIT;
                        cnt_d   = '0;
                        wait_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            // Timeout budget covers every cycle spent waiting or polling and
            // takes priority over the normal wait/poll progression.
            POLL_WAIT: begin
                if (tmo_q == TMO_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (wait_q == 3'd7) begin
                        state_d = POLL_RD;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end
            end
            POLL_RD: begin
                if (tmo_q == TMO_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (bus.axi_rd_data[0]) begin
                        state_d = RESULT_RD;
                    end else begin
                        state_d = POLL_WAIT;
                        wait_d  = '0;
                    end
                end
            end
            RESULT_RD: begin
                result_d = bus.axi_rd_data[5:0];
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            result_q  <= result_d;
            wr_en_q   <= accept;
            if (accept) begin
                wr_data_q <= bus.src_data;
                wr_addr_q <= wr_addr_nxt;
            end
        end
    end

    always_comb begin
        bus.axi_rd_en   = 1'b0;
        bus.axi_rd_addr = '0;
        if (state_q == POLL_RD) begin
            bus.axi_rd_en   = 1'b1;
            bus.axi_rd_addr = STATUS_ADDR;
        end else if (state_q == RESULT_RD) begin
            bus.axi_rd_en   = 1'b1;
            bus.axi_rd_addr = RESULT_ADDR;
        end
    end

    assign bus.src_ready     = src_ready;
    assign bus.axi_wr_en     = wr_en_q;
    assign bus.axi_wr_strobe = {8{wr_en_q}};
    assign bus.axi_wr_data   = wr_data_q;
    assign bus.axi_wr_addr   = wr_addr_q;
    assign result_class      = result_q;
    assign timeout_err       = timeout_q;
    assign done              = (state_q == DONE);
    assign busy              = (state_q != IDLE);
endmodule
